// File: rtl/ahb_master_seq_if.sv
// Command, write-data, read-data and AHB address-phase signals of the request sequencer.
// The master modport is the sequencer's view; slave is the command source / bus side.
interface ahb_master_seq_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_write_i;
  logic [AW-1:0] cmd_addr_i;
  logic [2:0]    cmd_burst_i;
  logic [3:0]    cmd_len_i;
  logic [DW-1:0] wdata_i;
  logic          wdata_valid_i;
  logic          wdata_ready_o;
  logic          grant_i;
  logic          hready_i;
  logic [DW-1:0] rdata_i;
  logic          req_o;
  logic          lock_o;
  logic          write_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [2:0]    burst_o;
  logic [DW-1:0] rdata_o;
  logic          rvalid_o;
  logic          done_o;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_burst_i, cmd_len_i,
           wdata_i, wdata_valid_i, grant_i, hready_i, rdata_i,
    output cmd_ready_o, wdata_ready_o, req_o, lock_o, write_o, addr_o,
           wdata_o, burst_o, rdata_o, rvalid_o, done_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_burst_i, cmd_len_i,
           wdata_i, wdata_valid_i, grant_i, hready_i, rdata_i,
    input  cmd_ready_o, wdata_ready_o, req_o, lock_o, write_o, addr_o,
           wdata_o, burst_o, rdata_o, rvalid_o, done_o
  );
endinterface

// File: rtl/ahb_master_seq.sv
// AHB master request sequencer: one command at a time, steps beat addresses for
// SINGLE/INCR/WRAP bursts and inserts a fixed idle gap after every transaction.
module ahb_master_seq #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int GAP     = 6,
  parameter int LOCK_EN = 1
) (
  input logic              clk,
  input logic              rst_n,
  ahb_master_seq_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, HOLD} state_e;

  localparam int            BW       = $clog2(DW / 8);
  localparam logic [AW-1:0] STEP     = AW'(DW / 8);
  localparam logic [AW-1:0] LOW_MASK = STEP - AW'(1);
  localparam int            GW       = (GAP < 2) ? 1 : $clog2(GAP);
  localparam logic [GW-1:0] GAP_LOAD = (GAP == 0) ? '0 : GW'(GAP - 1);
  localparam logic          LOCK_BIT = (LOCK_EN != 0);

  state_e        state_q, state_d;
  logic          ready_q;
  logic          write_q;
  logic [AW-1:0] addr_q;
  logic [2:0]    burst_q;
  logic [3:0]    left_q;
  logic          wrap_q;
  logic [AW-1:0] wrap_mask_q;
  logic [GW-1:0] gap_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          wready_q;
  logic          rvalid_q;
  logic          done_q;

  logic          accept;
  logic          beat;
  logic          last;
  logic [3:0]    cmd_left;
  logic [AW-1:0] cmd_mask;
  logic          cmd_wrap;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] addr_nxt;

  assign accept = bus.cmd_valid_i && ready_q;
  assign beat   = (state_q == XFER) && bus.hready_i && (!write_q || bus.wdata_valid_i);
  assign last   = (left_q == 4'd0);

  // Beats-1 per burst type; the wrap mask is (beats * step) - 1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cmd_left = 4'd0;
    unique case (bus.cmd_burst_i)
      3'd0:       cmd_left = 4'd0;
      3'd1:       cmd_left = bus.cmd_len_i;
      3'd2, 3'd3: cmd_left = 4'd3;
      3'd4, 3'd5: cmd_left = 4'd7;
      default:    cmd_left = 4'd15;
    endcase
  end

  assign cmd_mask = (AW'(cmd_left) << BW) | LOW_MASK;
  assign cmd_wrap = (bus.cmd_burst_i != 3'd0) && !bus.cmd_burst_i[0];

  // WRAP bursts keep the bits above the boundary and roll the bits below it.
  assign addr_inc = addr_q + STEP;
  assign addr_nxt = wrap_q ? ((addr_q & ~wrap_mask_q) | (addr_inc & wrap_mask_q)) : addr_inc;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)        state_d = REQ;
      REQ:  if (bus.grant_i)   state_d = XFER;
      XFER: if (beat && last)  state_d = HOLD;
      HOLD: if (gap_q == '0)   state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      burst_q     <= 3'd0;
      left_q      <= 4'd0;
      wrap_q      <= 1'b0;
      wrap_mask_q <= '0;
      gap_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wready_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // Ready is registered so it stays low for one cycle after reset release.
      ready_q  <= (state_d == IDLE);
      wready_q <= beat && write_q;
      rvalid_q <= beat && !write_q;
      done_q   <= beat && last;

      if (accept) begin
        write_q     <= bus.cmd_write_i;
        addr_q      <= bus.cmd_addr_i & ~LOW_MASK;
        burst_q     <= bus.cmd_burst_i;
        left_q      <= cmd_left;
        wrap_q      <= cmd_wrap;
        wrap_mask_q <= cmd_mask;
      end

      if (beat) begin
        if (write_q) wdata_q <= bus.wdata_i;
        else         rdata_q <= bus.rdata_i;
        if (!last) begin
          left_q <= left_q - 4'd1;
          addr_q <= addr_nxt;
        end
      end

      if (beat && last)                       gap_q <= GAP_LOAD;
      else if (state_q == HOLD && gap_q != '0) gap_q <= gap_q - GW'(1);
    end
  end

  always_comb begin
    bus.cmd_ready_o   = ready_q;
    bus.req_o         = (state_q == REQ) || (state_q == XFER);
    bus.lock_o        = bus.req_o && LOCK_BIT;
    bus.write_o       = bus.req_o && write_q;
    bus.addr_o        = (state_q != IDLE) ? addr_q  : '0;
    bus.burst_o       = (state_q != IDLE) ? burst_q : 3'd0;
    bus.wdata_o       = (state_q != IDLE) ? wdata_q : '0;
    bus.rdata_o       = (state_q != IDLE) ? rdata_q : '0;
    bus.wdata_ready_o = wready_q;
    bus.rvalid_o      = rvalid_q;
    bus.done_o        = done_q;
  end

endmodule

// File: tb/tb_ahb_master_seq.sv
// Self-checking bench for ahb_master_seq: directed scenarios plus randomized commands
// compared against an address/beat model derived from the burst rules.
module tb_ahb_master_seq;

  localparam int   AW       = 32;
  localparam int   DW       = 32;
  localparam int   GAP      = 6;
  localparam int   LOCK_EN  = 1;
  localparam int   STEP     = DW / 8;
  localparam int   HOLD_CYC = (GAP == 0) ? 1 : GAP;
  localparam logic LOCK_BIT = (LOCK_EN != 0);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ahb_master_seq_if #(.AW(AW), .DW(DW)) bus ();

  ahb_master_seq #(.AW(AW), .DW(DW), .GAP(GAP), .LOCK_EN(LOCK_EN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d errors", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int beats_of(input logic [2:0] b, input logic [3:0] len);
    case (b)
      3'd0:       return 1;
      3'd1:       return int'(len) + 1;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  // Address of beat i: aligned start plus i steps, folded inside the wrap window for WRAP types.
  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input logic [2:0] b,
                                              input int n, input int i);
    logic [AW-1:0] al, bnd, base;
    al = a - (a % AW'(STEP));
    if (b == 3'd2 || b == 3'd4 || b == 3'd6) begin
      bnd  = AW'(n * STEP);
      base = al - (al % bnd);
      return base + ((al - base + AW'(i * STEP)) % bnd);
    end
    return al + AW'(i * STEP);
  endfunction

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 2 * HOLD_CYC + 8 && bus.cmd_ready_o !== 1'b1; k++) tick();
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout: cmd_ready_o=%b expected 1", tag, bus.cmd_ready_o);
    end
  endtask

  // One full transaction: command, grant after gdly cycles, beats, done pulse and idle gap.
  task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [2:0] b,
                         input logic [3:0] len, input int gdly, input bit rnd,
                         input int stall_beat, input int stall_n, input string tag);
    int n, idx, stalls;
    logic [DW-1:0] wd, rd;
    logic hr, wv, bt;
    logic [AW-1:0] ea;
    n = beats_of(b, len);
    wait_ready(tag);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = wr;
    bus.cmd_addr_i  = a;
    bus.cmd_burst_i = b;
    bus.cmd_len_i   = len;
    tick();
    bus.cmd_valid_i = 1'b0;

    ea = beat_addr(a, b, n, 0);
    for (int g = 0; g <= gdly; g++) begin
      checks++;
      if ({bus.req_o, bus.lock_o, bus.write_o, bus.burst_o, bus.addr_o, bus.cmd_ready_o,
           bus.wdata_ready_o, bus.rvalid_o, bus.done_o} !==
          {1'b1, LOCK_BIT, wr, b, ea, 4'b0000}) begin
        errors++;
        $display("FAIL %s req_phase cyc%0d: req/lock/wr/burst/addr/rdy/pulses=%b/%b/%b/%0d/%h/%b/%b%b%b expected 1/%b/%b/%0d/%h/0/000",
                 tag, g, bus.req_o, bus.lock_o, bus.write_o, bus.burst_o, bus.addr_o, bus.cmd_ready_o,
                 bus.wdata_ready_o, bus.rvalid_o, bus.done_o, LOCK_BIT, wr, b, ea);
      end
      // hready and a competing command are offered while waiting; both must be ignored.
      bus.grant_i       = (g == gdly);
      bus.hready_i      = 1'b1;
      bus.wdata_valid_i = 1'b1;
      bus.cmd_valid_i   = (g != gdly);
      bus.cmd_addr_i    = $urandom;
      tick();
    end
    bus.grant_i     = 1'b0;
    bus.cmd_valid_i = 1'b0;

    idx = 0;
    stalls = 0;
    for (int cyc = 0; cyc < 400 && idx < n; cyc++) begin
      ea = beat_addr(a, b, n, idx);
      checks++;
      if ({bus.req_o, bus.lock_o, bus.write_o, bus.burst_o, bus.addr_o} !== {1'b1, LOCK_BIT, wr, b, ea}) begin
        errors++;
        $display("FAIL %s xfer_phase beat%0d: req/lock/wr/burst/addr=%b/%b/%b/%0d/%h expected 1/%b/%b/%0d/%h",
                 tag, idx, bus.req_o, bus.lock_o, bus.write_o, bus.burst_o, bus.addr_o, LOCK_BIT, wr, b, ea);
      end
      if (rnd) begin
        hr = ($urandom_range(0, 3) != 0);
        wv = ($urandom_range(0, 3) != 0);
        wd = $urandom;
        rd = $urandom;
      end else begin
        hr = 1'b1;
        wv = !(idx == stall_beat && stalls < stall_n);
        if (!wv) stalls++;
        wd = 32'hDEADBEEF + idx;
        rd = idx + 1;
      end
      bus.hready_i      = hr;
      bus.wdata_valid_i = wv;
      bus.wdata_i       = wd;
      bus.rdata_i       = rd;
      bt = hr && (!wr || wv);
      tick();
      if (bt) idx++;
      checks++;
      if ({bus.wdata_ready_o, bus.rvalid_o, bus.done_o} !== {bt && wr, bt && !wr, bt && (idx == n)}) begin
        errors++;
        $display("FAIL %s pulses beat%0d: wready/rvalid/done=%b%b%b expected %b%b%b", tag, idx,
                 bus.wdata_ready_o, bus.rvalid_o, bus.done_o, bt && wr, bt && !wr, bt && (idx == n));
      end
      if (bt) begin
        checks++;
        if ((wr ? bus.wdata_o : bus.rdata_o) !== (wr ? wd : rd)) begin
          errors++;
          $display("FAIL %s beat_data beat%0d: got %h expected %h", tag, idx,
                   wr ? bus.wdata_o : bus.rdata_o, wr ? wd : rd);
        end
      end
    end
    bus.hready_i      = 1'b0;
    bus.wdata_valid_i = 1'b0;

    for (int h = 0; h < HOLD_CYC; h++) begin
      checks++;
      if ({bus.req_o, bus.lock_o, bus.write_o, bus.cmd_ready_o, bus.burst_o} !== {4'b0000, b}) begin
        errors++;
        $display("FAIL %s hold cyc%0d: req/lock/wr/rdy/burst=%b/%b/%b/%b/%0d expected 0/0/0/0/%0d",
                 tag, h, bus.req_o, bus.lock_o, bus.write_o, bus.cmd_ready_o, bus.burst_o, b);
      end
      if (h > 0) begin
        checks++;
        if (bus.done_o !== 1'b0) begin
          errors++;
          $display("FAIL %s done_extra cyc%0d: done_o=%b expected 0", tag, h, bus.done_o);
        end
      end
      tick();
    end
    checks++;
    if ({bus.cmd_ready_o, bus.req_o, bus.addr_o} !== {1'b1, 1'b0, {AW{1'b0}}}) begin
      errors++;
      $display("FAIL %s idle_after_gap: rdy/req/addr=%b/%b/%h expected 1/0/0", tag,
               bus.cmd_ready_o, bus.req_o, bus.addr_o);
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_burst_i = 3'd0;
    bus.cmd_len_i = 4'd0; bus.wdata_i = '0; bus.wdata_valid_i = 1'b0; bus.grant_i = 1'b0;
    bus.hready_i = 1'b0; bus.rdata_i = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.cmd_ready_o, bus.wdata_ready_o, bus.req_o, bus.lock_o, bus.write_o, bus.addr_o,
         bus.wdata_o, bus.burst_o, bus.rdata_o, bus.rvalid_o, bus.done_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b req=%b lock=%b addr=%h burst=%0d done=%b expected all 0",
               bus.cmd_ready_o, bus.req_o, bus.lock_o, bus.addr_o, bus.burst_o, bus.done_o);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: cmd_ready_o=%b expected 1", bus.cmd_ready_o);
    end
  endtask

  task automatic test_single_write();
    run_txn(1'b1, 32'h0000_0100, 3'd0, 4'd0, 1, 1'b0, -1, 0, "single_write");
  endtask

  task automatic test_incr4_read();
    run_txn(1'b0, 32'h0000_0200, 3'd3, 4'd0, 0, 1'b0, -1, 0, "incr4_read");
  endtask

  task automatic test_wrap4_write();
    run_txn(1'b1, 32'h0000_0038, 3'd2, 4'd0, 0, 1'b0, -1, 0, "wrap4_write");
  endtask

  task automatic test_incr_stall();
    run_txn(1'b1, 32'h0000_1000, 3'd1, 4'd2, 0, 1'b0, 1, 2, "incr_stall");
  endtask

  task automatic test_grant_wait();
    run_txn(1'b0, 32'h0000_4444, 3'd5, 4'd0, 10, 1'b0, -1, 0, "grant_wait");
  endtask

  task automatic test_reset_mid_burst();
    logic [AW-1:0] a, ea;
    a = $urandom & 32'hFFFF_FFFC;
    wait_ready("reset_mid");
    bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b1; bus.cmd_addr_i = a;
    bus.cmd_burst_i = 3'd5; bus.cmd_len_i = 4'd0;
    tick();
    bus.cmd_valid_i = 1'b0;
    bus.grant_i = 1'b1;
    tick();
    bus.grant_i = 1'b0;
    bus.hready_i = 1'b1; bus.wdata_valid_i = 1'b1; bus.wdata_i = $urandom;
    repeat (2) tick();
    bus.hready_i = 1'b0;
    tick();
    ea = beat_addr(a, 3'd5, 8, 2);
    checks++;
    if ({bus.req_o, bus.addr_o} !== {1'b1, ea}) begin
      errors++;
      $display("FAIL reset_mid beat3_addr: req/addr=%b/%h expected 1/%h", bus.req_o, bus.addr_o, ea);
    end
    rst_n = 1'b0;
    bus.hready_i = 1'b1;
    tick();
    checks++;
    if ({bus.cmd_ready_o, bus.wdata_ready_o, bus.req_o, bus.lock_o, bus.write_o, bus.addr_o,
         bus.wdata_o, bus.burst_o, bus.rdata_o, bus.rvalid_o, bus.done_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: rdy=%b wrdy=%b req=%b lock=%b addr=%h burst=%0d done=%b expected all 0",
               bus.cmd_ready_o, bus.wdata_ready_o, bus.req_o, bus.lock_o, bus.addr_o, bus.burst_o, bus.done_o);
    end
    rst_n = 1'b1;
    bus.hready_i = 1'b0; bus.wdata_valid_i = 1'b0;
    tick();
    checks++;
    if ({bus.cmd_ready_o, bus.req_o, bus.done_o} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid release: rdy/req/done=%b/%b/%b expected 1/0/0",
               bus.cmd_ready_o, bus.req_o, bus.done_o);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int t = 0; t < 24; t++) begin
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | AW'($urandom_range(0, 63))) : AW'($urandom);
      run_txn(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), 1'b1, -1, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_incr4_read();
    test_wrap4_write();
    test_incr_stall();
    test_grant_wait();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
